// File: rtl/adc_sample_scheduler.sv
// rtl/adc_sample_scheduler.sv - 50 Hz ADC sample slot scheduler
// Issues SAMPLES_PER_CYCLE evenly spaced conversions per mains cycle, flagging overrun, timeout and resync.
module adc_sample_scheduler #(
   parameter int SAMPLES_PER_CYCLE = 64,
   parameter int SAMPLE_INTERVAL   = 1024,
   parameter int TIMEOUT           = 512
) (
   input  logic                                 CLK,
   input  logic                                 RST,
   input  logic                                 PULSE_50_HZ,
   input  logic                                 EN,
   input  logic                                 ADC_BUSY,
   input  logic                                 ADC_DONE,
   input  logic                                 CLR_ERR,
   output logic                                 ADC_START,
   output logic [$clog2(SAMPLES_PER_CYCLE)-1:0] SAMPLE_INDEX,
   output logic                                 SAMPLE_VALID,
   output logic                                 CYCLE_DONE,
   output logic                                 OVERRUN,
   output logic                                 TIMEOUT_ERR,
   output logic                                 SYNC_ERR
);
   localparam int IDX_W = $clog2(SAMPLES_PER_CYCLE);
   localparam int TMR_W = $clog2(SAMPLE_INTERVAL);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SAMPLES_PER_CYCLE - 1);
   localparam logic [TMR_W-1:0] SLOT_LAST = TMR_W'(SAMPLE_INTERVAL - 1);
   localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT - 1);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_CONVERT   = 2'd1;
   localparam logic [1:0] ST_WAIT_SLOT = 2'd2;

   logic [1:0]       state;
   logic [TMR_W-1:0] timer;
   logic             restart_pend;
   logic [IDX_W-1:0] next_idx;
   logic             conv_ok;
   logic             conv_to;
   logic             slot_exp;
   logic             final_done;
   logic             resync;

   always_comb begin
      next_idx   = SAMPLE_INDEX + IDX_W'(1);
      conv_ok    = (state == ST_CONVERT) && ADC_DONE;
      conv_to    = (state == ST_CONVERT) && !ADC_DONE && (timer == TO_LAST);
      slot_exp   = (state == ST_WAIT_SLOT) && (timer == SLOT_LAST);
      final_done = ((conv_ok || conv_to) && (SAMPLE_INDEX == LAST_IDX)) ||
                   (slot_exp && ADC_BUSY && (next_idx == LAST_IDX));
      // A cycle pulse landing on the final slot's completion is a clean restart, not a resync.
      resync     = (state != ST_IDLE) && PULSE_50_HZ && !final_done;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= ST_IDLE;
         timer        <= '0;
         restart_pend <= 1'b0;
         SAMPLE_INDEX <= '0;
         ADC_START    <= 1'b0;
         SAMPLE_VALID <= 1'b0;
         CYCLE_DONE   <= 1'b0;
         OVERRUN      <= 1'b0;
         TIMEOUT_ERR  <= 1'b0;
         SYNC_ERR     <= 1'b0;
      end else begin
         ADC_START    <= 1'b0;
         SAMPLE_VALID <= 1'b0;
         CYCLE_DONE   <= 1'b0;
         timer        <= timer + TMR_W'(1);
         // Clear first so an error event later in this block wins.
         if (CLR_ERR) begin
            OVERRUN     <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            SYNC_ERR    <= 1'b0;
         end
         if (resync) begin
            SYNC_ERR     <= 1'b1;
            state        <= ST_CONVERT;
            SAMPLE_INDEX <= '0;
            ADC_START    <= 1'b1;
            timer        <= '0;
            restart_pend <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  restart_pend <= 1'b0;
                  if (EN && (PULSE_50_HZ || restart_pend)) begin
                     state        <= ST_CONVERT;
                     SAMPLE_INDEX <= '0;
                     ADC_START    <= 1'b1;
                     timer        <= '0;
                  end
               end
               ST_CONVERT: begin
                  if (conv_ok || conv_to) begin
                     SAMPLE_VALID <= conv_ok;
                     if (conv_to) TIMEOUT_ERR <= 1'b1;
                     if (SAMPLE_INDEX == LAST_IDX) begin
                        CYCLE_DONE   <= 1'b1;
                        state        <= ST_IDLE;
                        restart_pend <= PULSE_50_HZ;
                     end else begin
                        state <= ST_WAIT_SLOT;
                     end
                  end
               end
               ST_WAIT_SLOT: begin
                  if (slot_exp) begin
                     SAMPLE_INDEX <= next_idx;
                     timer        <= '0;
                     if (ADC_BUSY) begin
                        OVERRUN <= 1'b1;
                        if (next_idx == LAST_IDX) begin
                           CYCLE_DONE   <= 1'b1;
                           state        <= ST_IDLE;
                           restart_pend <= PULSE_50_HZ;
                        end
                     end else begin
                        ADC_START <= 1'b1;
                        state     <= ST_CONVERT;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_adc_sample_scheduler.sv
// tb/tb_adc_sample_scheduler.sv - self-checking bench for adc_sample_scheduler
// Expected event times are derived from slot arithmetic: slot k starts at pulse+1+16k.
module tb_adc_sample_scheduler;
   localparam int SPC = 4;
   localparam int SI  = 16;
   localparam int TO  = 8;

   logic       CLK = 1'b0;
   logic       RST;
   logic       PULSE_50_HZ;
   logic       EN;
   logic       ADC_BUSY;
   logic       ADC_DONE;
   logic       CLR_ERR;
   logic       ADC_START;
   logic [1:0] SAMPLE_INDEX;
   logic       SAMPLE_VALID;
   logic       CYCLE_DONE;
   logic       OVERRUN;
   logic       TIMEOUT_ERR;
   logic       SYNC_ERR;

   int errors = 0;
   int checks = 0;

   adc_sample_scheduler #(.SAMPLES_PER_CYCLE(SPC), .SAMPLE_INTERVAL(SI), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST), .PULSE_50_HZ(PULSE_50_HZ), .EN(EN), .ADC_BUSY(ADC_BUSY),
      .ADC_DONE(ADC_DONE), .CLR_ERR(CLR_ERR), .ADC_START(ADC_START), .SAMPLE_INDEX(SAMPLE_INDEX),
      .SAMPLE_VALID(SAMPLE_VALID), .CYCLE_DONE(CYCLE_DONE), .OVERRUN(OVERRUN),
      .TIMEOUT_ERR(TIMEOUT_ERR), .SYNC_ERR(SYNC_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1; PULSE_50_HZ = 1'b0; EN = 1'b0; ADC_BUSY = 1'b0; ADC_DONE = 1'b0; CLR_ERR = 1'b0;
      #2;
      checks++;
      if ({ADC_START, SAMPLE_INDEX, SAMPLE_VALID, CYCLE_DONE, OVERRUN, TIMEOUT_ERR, SYNC_ERR} !== 8'h00) begin
         errors++;
         $display("FAIL reset_initial got=%b exp=00000000",
                  {ADC_START, SAMPLE_INDEX, SAMPLE_VALID, CYCLE_DONE, OVERRUN, TIMEOUT_ERR, SYNC_ERR});
      end
      PULSE_50_HZ = 1'b1; EN = 1'b1; ADC_DONE = 1'b1; ADC_BUSY = 1'b1;
      repeat (3) tick();
      checks++;
      if ({ADC_START, SAMPLE_INDEX, SAMPLE_VALID, CYCLE_DONE, OVERRUN, TIMEOUT_ERR, SYNC_ERR} !== 8'h00) begin
         errors++;
         $display("FAIL reset_held got=%b exp=00000000",
                  {ADC_START, SAMPLE_INDEX, SAMPLE_VALID, CYCLE_DONE, OVERRUN, TIMEOUT_ERR, SYNC_ERR});
      end
      PULSE_50_HZ = 1'b0; EN = 1'b0; ADC_DONE = 1'b0; ADC_BUSY = 1'b0; RST = 1'b0;
      tick();
   endtask

   // One full 50 Hz cycle: skip[k] forces ADC_BUSY at slot k's decision, d[k]>7 means no ADC_DONE.
   task automatic run_trial(input string name, input int p, input logic [3:0] skip,
                            input int d0, input int d1, input int d2, input int d3, input int clr_at);
      int s[4];
      int d[4];
      int len;
      int ov_ev[$];
      int to_ev[$];
      bit st_e[128], v_e[128], cd_e[128], done_d[128], busy_ctl[128], busy_val[128];
      int idx_e[128];
      bit exp_ov, exp_to;
      d = '{d0, d1, d2, d3};
      for (int i = 0; i < 128; i++) begin
         st_e[i] = 0; v_e[i] = 0; cd_e[i] = 0; done_d[i] = 0; busy_ctl[i] = 0; busy_val[i] = 0; idx_e[i] = 0;
      end
      for (int k = 0; k < 4; k++) begin
         s[k] = p + 1 + SI * k;
         if (k > 0) begin
            busy_ctl[s[k]-1] = 1;
            busy_val[s[k]-1] = skip[k];
         end
         if (k > 0 && skip[k]) begin
            ov_ev.push_back(s[k]);
            done_d[s[k]+3] = 1;
            if (k == 3) cd_e[s[k]] = 1;
         end else begin
            st_e[s[k]] = 1;
            idx_e[s[k]] = k;
            if (d[k] <= TO - 1) begin
               done_d[s[k]+d[k]] = 1;
               v_e[s[k]+d[k]+1] = 1;
               idx_e[s[k]+d[k]+1] = k;
               done_d[s[k]+12] = 1;
               if (k == 3) cd_e[s[k]+d[k]+1] = 1;
            end else begin
               to_ev.push_back(s[k] + TO);
               done_d[s[k]+10] = 1;
               if (k == 3) cd_e[s[k]+TO] = 1;
            end
         end
      end
      len = s[3] + 18;
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      for (int c = 0; c < len; c++) begin
         PULSE_50_HZ = (c == p);
         EN          = (c == p) ? 1'b1 : 1'($urandom_range(0, 1));
         CLR_ERR     = (c == clr_at);
         ADC_DONE    = done_d[c];
         ADC_BUSY    = busy_ctl[c] ? busy_val[c] : 1'($urandom_range(0, 1));
         exp_ov = 0;
         exp_to = 0;
         foreach (ov_ev[j]) if (ov_ev[j] <= c && (clr_at < 0 || c <= clr_at || ov_ev[j] > clr_at)) exp_ov = 1;
         foreach (to_ev[j]) if (to_ev[j] <= c && (clr_at < 0 || c <= clr_at || to_ev[j] > clr_at)) exp_to = 1;
         checks++;
         if ({ADC_START, SAMPLE_VALID, CYCLE_DONE} !== {st_e[c], v_e[c], cd_e[c]}) begin
            errors++;
            $display("FAIL %s pulses c=%0d got start/valid/done=%b exp=%b", name, c,
                     {ADC_START, SAMPLE_VALID, CYCLE_DONE}, {st_e[c], v_e[c], cd_e[c]});
         end
         checks++;
         if ({OVERRUN, TIMEOUT_ERR, SYNC_ERR} !== {exp_ov, exp_to, 1'b0}) begin
            errors++;
            $display("FAIL %s flags c=%0d got ovr/to/sync=%b exp=%b", name, c,
                     {OVERRUN, TIMEOUT_ERR, SYNC_ERR}, {exp_ov, exp_to, 1'b0});
         end
         if (st_e[c] || v_e[c]) begin
            checks++;
            if (SAMPLE_INDEX !== 2'(idx_e[c])) begin
               errors++;
               $display("FAIL %s index c=%0d got=%0d exp=%0d", name, c, SAMPLE_INDEX, idx_e[c]);
            end
         end
         tick();
      end
      PULSE_50_HZ = 1'b0; EN = 1'b0; CLR_ERR = 1'b0; ADC_DONE = 1'b0; ADC_BUSY = 1'b0;
   endtask

   // Directed sequence with explicit pulse, start, done and cycle-done times.
   task automatic run_directed(input string name, input int pl[$], input int st[$], input int sidx[$],
                               input int dn[$], input int vidx[$], input int cds[$],
                               input int sync_from, input int len);
      bit st_e[128], v_e[128], cd_e[128], done_d[128], pl_e[128];
      int idx_e[128];
      bit exp_sync;
      for (int i = 0; i < 128; i++) begin
         st_e[i] = 0; v_e[i] = 0; cd_e[i] = 0; done_d[i] = 0; pl_e[i] = 0; idx_e[i] = 0;
      end
      foreach (pl[j]) pl_e[pl[j]] = 1;
      foreach (st[j]) begin st_e[st[j]] = 1; idx_e[st[j]] = sidx[j]; end
      foreach (dn[j]) begin done_d[dn[j]] = 1; v_e[dn[j]+1] = 1; idx_e[dn[j]+1] = vidx[j]; end
      foreach (cds[j]) cd_e[cds[j]] = 1;
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      for (int c = 0; c < len; c++) begin
         PULSE_50_HZ = pl_e[c]; EN = 1'b1; ADC_BUSY = 1'b0; ADC_DONE = done_d[c];
         exp_sync = (sync_from >= 0) && (c >= sync_from);
         checks++;
         if ({ADC_START, SAMPLE_VALID, CYCLE_DONE} !== {st_e[c], v_e[c], cd_e[c]}) begin
            errors++;
            $display("FAIL %s pulses c=%0d got start/valid/done=%b exp=%b", name, c,
                     {ADC_START, SAMPLE_VALID, CYCLE_DONE}, {st_e[c], v_e[c], cd_e[c]});
         end
         checks++;
         if ({OVERRUN, TIMEOUT_ERR, SYNC_ERR} !== {2'b00, exp_sync}) begin
            errors++;
            $display("FAIL %s flags c=%0d got ovr/to/sync=%b exp=%b", name, c,
                     {OVERRUN, TIMEOUT_ERR, SYNC_ERR}, {2'b00, exp_sync});
         end
         if (st_e[c] || v_e[c]) begin
            checks++;
            if (SAMPLE_INDEX !== 2'(idx_e[c])) begin
               errors++;
               $display("FAIL %s index c=%0d got=%0d exp=%0d", name, c, SAMPLE_INDEX, idx_e[c]);
            end
         end
         tick();
      end
      PULSE_50_HZ = 1'b0; ADC_DONE = 1'b0; EN = 1'b0;
   endtask

   task automatic test_nominal();
      run_trial("nominal", 10, 4'b0000, 5, 5, 5, 5, -1);
   endtask

   task automatic test_overrun();
      run_trial("overrun", 10, 4'b0100, 5, 5, 5, 5, -1);
   endtask

   task automatic test_timeout();
      run_trial("timeout_clr_same_cycle", 10, 4'b0000, 5, 9, 5, 5, 34);
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 8; t++) begin
         logic [3:0] sk;
         int clr;
         sk  = {3'($urandom_range(0, 7)), 1'b0};
         clr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(12, 60)) : -1;
         run_trial("random", int'($urandom_range(1, 6)), sk, int'($urandom_range(1, 9)),
                   int'($urandom_range(1, 9)), int'($urandom_range(1, 9)), int'($urandom_range(1, 9)), clr);
      end
   endtask

   task automatic test_sync();
      int pl[$], st[$], sidx[$], dn[$], vidx[$], cds[$];
      pl = {10, 30}; st = {11, 27, 31, 47, 63, 79}; sidx = {0, 1, 0, 1, 2, 3};
      dn = {16, 36, 52, 68, 84}; vidx = {0, 0, 1, 2, 3}; cds = {85};
      run_directed("sync", pl, st, sidx, dn, vidx, cds, 31, 95);
   endtask

   task automatic test_final_pulse();
      int pl[$], st[$], sidx[$], dn[$], vidx[$], cds[$];
      pl = {2, 56}; st = {3, 19, 35, 51, 58, 74, 90, 106}; sidx = {0, 1, 2, 3, 0, 1, 2, 3};
      dn = {8, 24, 40, 56, 63, 79, 95, 111}; vidx = {0, 1, 2, 3, 0, 1, 2, 3}; cds = {57, 112};
      run_directed("final_pulse", pl, st, sidx, dn, vidx, cds, -1, 120);
   endtask

   task automatic test_en_idle();
      for (int c = 0; c < 40; c++) begin
         EN = 1'b0; PULSE_50_HZ = (c % 5 == 0); ADC_DONE = 1'($urandom_range(0, 1)); ADC_BUSY = 1'b0;
         checks++;
         if ({ADC_START, SAMPLE_VALID, CYCLE_DONE} !== 3'b000) begin
            errors++;
            $display("FAIL en_low c=%0d got start/valid/done=%b exp=000", c, {ADC_START, SAMPLE_VALID, CYCLE_DONE});
         end
         tick();
      end
      PULSE_50_HZ = 1'b0; ADC_DONE = 1'b0;
   endtask

   task automatic test_reset_mid();
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      for (int c = 0; c < 22; c++) begin
         PULSE_50_HZ = (c == 10); EN = 1'b1; ADC_DONE = 1'b0; ADC_BUSY = 1'b0;
         if (c == 11) begin
            checks++;
            if (ADC_START !== 1'b1) begin errors++; $display("FAIL rst_pre_start got=%b exp=1", ADC_START); end
         end
         if (c == 19) begin
            checks++;
            if (TIMEOUT_ERR !== 1'b1) begin errors++; $display("FAIL rst_pre_timeout got=%b exp=1", TIMEOUT_ERR); end
         end
         if (c == 20) begin
            RST = 1'b1;
            #2;
            checks++;
            if ({ADC_START, SAMPLE_INDEX, SAMPLE_VALID, CYCLE_DONE, OVERRUN, TIMEOUT_ERR, SYNC_ERR} !== 8'h00) begin
               errors++;
               $display("FAIL rst_async got=%b exp=00000000",
                        {ADC_START, SAMPLE_INDEX, SAMPLE_VALID, CYCLE_DONE, OVERRUN, TIMEOUT_ERR, SYNC_ERR});
            end
         end
         tick();
      end
      RST = 1'b0;
      for (int c = 22; c < 60; c++) begin
         PULSE_50_HZ = 1'b0; EN = 1'($urandom_range(0, 1)); ADC_DONE = 1'($urandom_range(0, 1));
         ADC_BUSY = 1'($urandom_range(0, 1)); CLR_ERR = (c == 40);
         checks++;
         if ({ADC_START, SAMPLE_INDEX, SAMPLE_VALID, CYCLE_DONE, OVERRUN, TIMEOUT_ERR, SYNC_ERR} !== 8'h00) begin
            errors++;
            $display("FAIL rst_quiet c=%0d got=%b exp=00000000", c,
                     {ADC_START, SAMPLE_INDEX, SAMPLE_VALID, CYCLE_DONE, OVERRUN, TIMEOUT_ERR, SYNC_ERR});
         end
         tick();
      end
      CLR_ERR = 1'b0; PULSE_50_HZ = 1'b1; EN = 1'b1; ADC_DONE = 1'b0; ADC_BUSY = 1'b0;
      tick();
      PULSE_50_HZ = 1'b0;
      checks++;
      if ({ADC_START, SAMPLE_INDEX} !== 3'b100) begin
         errors++;
         $display("FAIL rst_restart got start/index=%b exp=100", {ADC_START, SAMPLE_INDEX});
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_overrun();
      test_timeout();
      test_back_to_back();
      test_sync();
      test_final_pulse();
      test_en_idle();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
